// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter: round-robin arbiter that shares one square-root engine among
// NREQ requesters, with exactly one operation in flight.
//
// Optional feature: define SQRT_ARB_TIMEOUT_EN to enable a WAIT-state watchdog.
// If the engine has not produced a result after TIMEOUT WAIT cycles, the block
// answers with rsp_err=1 and a zero root and remainder. Without the macro,
// rsp_err is tied to 0 and WAIT can last indefinitely.
//
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready    per-requester handshake; req_ready is one-hot or zero
//   req_rad                packed radicands, requester k at [k*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready    response handshake
//   rsp_id/root/rem/err    response payload, held stable while rsp_valid is high
//   sq_start/sq_rad        engine start pulse and radicand
//   sq_busy/sq_valid       engine status; sq_busy is only observed, never used
//   sq_root/sq_rem         engine result, valid while sq_valid is high
module sqrt_arbiter #(
    parameter int  WIDTH   = 8,
    parameter int  NREQ    = 4,
    parameter int  TIMEOUT = 64,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_rad,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_root,
    output logic [WIDTH-1:0]      rsp_rem,
    output logic                  rsp_err,
    output logic                  sq_start,
    output logic [WIDTH-1:0]      sq_rad,
    input  logic                  sq_busy,
    input  logic                  sq_valid,
    input  logic [WIDTH-1:0]      sq_root,
    input  logic [WIDTH-1:0]      sq_rem
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   last_grant_q, last_grant_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [WIDTH-1:0] rad_q, rad_d;
    logic [WIDTH-1:0] root_q, root_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    // High during the first WAIT cycle, when sq_valid may still show the
    // previous operation's result.
    logic             first_q, first_d;

`ifdef SQRT_ARB_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic             err_q, err_d;
    logic [WDW-1:0]   wd_q, wd_d;
`endif

    // Round-robin search upward from the requester after the last grant.
    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    int               cand;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = (int'(last_grant_q) + i) % NREQ;
            if (!grant_found && req_valid[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDW-1:0];
            end
        end
    end

    // Gated by rst so the accept strobe is low throughout reset.
    always_comb begin
        req_ready = '0;
        if (state_q == StIdle && grant_found && !rst) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        rad_d        = rad_q;
        root_d       = root_q;
        rem_d        = rem_q;
        first_d      = first_q;
`ifdef SQRT_ARB_TIMEOUT_EN
        err_d        = err_q;
        wd_d         = wd_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    rad_d        = req_rad[int'(grant_idx)*WIDTH +: WIDTH];
                    id_d         = grant_idx;
                    last_grant_d = grant_idx;
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                first_d = 1'b1;
`ifdef SQRT_ARB_TIMEOUT_EN
                wd_d    = '0;
`endif
                state_d = StWait;
            end
            StWait: begin
                first_d = 1'b0;
`ifdef SQRT_ARB_TIMEOUT_EN
                wd_d    = wd_q + WDW'(1);
`endif
                // A real result wins over a watchdog expiry in the same cycle.
                if (!first_q && sq_valid) begin
                    root_d  = sq_root;
                    rem_d   = sq_rem;
`ifdef SQRT_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = StResp;
                end
`ifdef SQRT_ARB_TIMEOUT_EN
                else if (wd_q == WDW'(TIMEOUT - 1)) begin
                    root_d  = '0;
                    rem_d   = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end
`endif
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= IDW'(NREQ - 1);
            id_q         <= '0;
            rad_q        <= '0;
            root_q       <= '0;
            rem_q        <= '0;
            first_q      <= 1'b0;
`ifdef SQRT_ARB_TIMEOUT_EN
            err_q        <= 1'b0;
            wd_q         <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            rad_q        <= rad_d;
            root_q       <= root_d;
            rem_q        <= rem_d;
            first_q      <= first_d;
`ifdef SQRT_ARB_TIMEOUT_EN
            err_q        <= err_d;
            wd_q         <= wd_d;
`endif
        end
    end

    assign sq_start  = (state_q == StIssue);
    assign sq_rad    = rad_q;
    assign rsp_valid = (state_q == StResp);
    assign rsp_id    = id_q;
    assign rsp_root  = root_q;
    assign rsp_rem   = rem_q;
`ifdef SQRT_ARB_TIMEOUT_EN
    assign rsp_err   = err_q;
`else
    assign rsp_err   = 1'b0;
`endif

    // Engine busy does not steer the FSM: a new start always restarts the engine.
    logic unused_sigs;
    assign unused_sigs = ^{sq_busy, 32'(TIMEOUT)};

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Bench for sqrt_arbiter: randomized and directed requests, a behavioural
// square-root engine, and a scoreboard of expected grants and responses.
module tb_sqrt_arbiter;

    localparam int WIDTH   = 8;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;
    localparam int IDW     = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_rad = '0;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b0;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_root, rsp_rem;
    logic                  rsp_err;
    logic                  sq_start;
    logic [WIDTH-1:0]      sq_rad;
    logic                  sq_busy, sq_valid;
    logic [WIDTH-1:0]      sq_root, sq_rem;

    always #5 clk = ~clk;

    sqrt_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rad(req_rad),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_root(rsp_root), .rsp_rem(rsp_rem), .rsp_err(rsp_err),
        .sq_start(sq_start), .sq_rad(sq_rad), .sq_busy(sq_busy),
        .sq_valid(sq_valid), .sq_root(sq_root), .sq_rem(sq_rem)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int isqrt(input int x);
        int r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    // Engine stub: registered start (so a stale sq_valid is still visible in
    // the first WAIT cycle), start overrides busy, no reset.
    bit               stall = 1'b0;
    int               eng_lat = 2;
    int               eng_cnt = 0;
    logic             start_d = 1'b0;
    logic             eng_busy = 1'b0;
    logic             eng_valid = 1'b0;
    logic [WIDTH-1:0] eng_root = '0;
    logic [WIDTH-1:0] eng_rem = '0;

    always @(posedge clk) begin
        start_d <= sq_start;
        if (start_d) begin
            eng_busy  <= 1'b1;
            eng_valid <= 1'b0;
            eng_cnt   <= eng_lat;
            eng_root  <= 8'(isqrt(int'(sq_rad)));
            eng_rem   <= 8'(int'(sq_rad) - isqrt(int'(sq_rad)) * isqrt(int'(sq_rad)));
        end else if (eng_busy && !stall) begin
            if (eng_cnt == 0) begin
                eng_busy  <= 1'b0;
                eng_valid <= 1'b1;
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    assign sq_busy  = eng_busy;
    assign sq_valid = eng_valid;
    assign sq_root  = eng_root;
    assign sq_rem   = eng_rem;

    // Scoreboard and reference model.
    typedef struct {
        int id;
        int root;
        int rem;
        int err;
        int gcyc;
    } exp_t;

    exp_t sb[$];
    int   glog[$];
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    int               ptr = NREQ - 1;
    bit               in_flight = 1'b0;
    bit               grant_prev = 1'b0;
    bit               rsp_seen = 1'b0;
    bit               prev_sqv = 1'b0;
    logic [WIDTH-1:0] last_rad = '0;
    logic [NREQ-1:0]  exp_ready;
    int               g, k;
    exp_t             e;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            ptr        = NREQ - 1;
            in_flight  = 1'b0;
            grant_prev = 1'b0;
            rsp_seen   = 1'b0;
            prev_sqv   = 1'b0;
        end else begin
            exp_ready = '0;
            g = -1;
            if (!in_flight) begin
                for (int i = 1; i <= NREQ; i++) begin
                    k = (ptr + i) % NREQ;
                    if (g < 0 && req_valid[k[IDW-1:0]]) g = k;
                end
            end
            if (g >= 0) exp_ready[g[IDW-1:0]] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("sq_start", 32'(sq_start), 32'(grant_prev));
            if (grant_prev) chk("sq_rad", 32'(sq_rad), 32'(last_rad));
            grant_prev = (g >= 0);
            if (g >= 0) begin
                ptr       = g;
                in_flight = 1'b1;
                last_rad  = req_rad[g*WIDTH +: WIDTH];
                glog.push_back(g);
                e.id   = g;
                e.gcyc = cyc;
                e.root = isqrt(int'(last_rad));
                e.rem  = int'(last_rad) - e.root * e.root;
                e.err  = 0;
`ifdef SQRT_ARB_TIMEOUT_EN
                if (stall) begin
                    e.root = 0;
                    e.rem  = 0;
                    e.err  = 1;
                end
`endif
                sb.push_back(e);
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 0);
                end else begin
                    chk("rsp_id", 32'(rsp_id), sb[0].id);
                    chk("rsp_root", 32'(rsp_root), sb[0].root);
                    chk("rsp_rem", 32'(rsp_rem), sb[0].rem);
                    chk("rsp_err", 32'(rsp_err), sb[0].err);
                    if (!rsp_seen) begin
                        if (sb[0].err != 0) chk("timeout_cycle", cyc, sb[0].gcyc + 2 + TIMEOUT);
                        else chk("rsp_latency", 32'(prev_sqv), 1);
                    end
                    if (rsp_ready) begin
                        void'(sb.pop_front());
                        in_flight = 1'b0;
                        rsp_seen  = 1'b0;
                    end else begin
                        rsp_seen = 1'b1;
                    end
                end
            end else if (rsp_seen) begin
                chk("rsp_dropped", 32'(rsp_valid), 1);
                rsp_seen = 1'b0;
            end
            prev_sqv = sq_valid;
        end
    end

    // Stimulus helpers.
    task automatic set_req(input int idx, input int rad);
        req_rad[idx*WIDTH +: WIDTH] = rad[WIDTH-1:0];
        req_valid[idx] = 1'b1;
    endtask

    task automatic tick(input bit keep);
        logic [NREQ-1:0] gr;
        @(negedge clk);
        gr = req_ready;
        @(posedge clk);
        #1;
        if (!keep) req_valid = req_valid & ~gr;
    endtask

    task automatic wait_drain(input int limit);
        rsp_ready = 1'b1;
        for (int n = 0; n < limit && (sb.size() != 0 || req_valid != 0); n++) tick(1'b0);
        chk("drain", sb.size(), 0);
    endtask

    task automatic chk_zero();
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_sq_start", 32'(sq_start), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_rsp_root", 32'(rsp_root), 0);
        chk("rst_rsp_rem", 32'(rsp_rem), 0);
        chk("rst_sq_rad", 32'(sq_rad), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    int order[5];
    int cnt;
    logic [NREQ-1:0] gr;

    initial begin
        order = '{0, 1, 2, 3, 0};

        // Reset values, with a request already pending.
        req_valid = 4'b1111;
        repeat (3) @(posedge clk);
        #1 chk_zero();
        req_valid = '0;
        #1 rst = 1'b0;
        repeat (3) tick(1'b0);

        // Single request from requester 2.
        rsp_ready = 1'b1;
        set_req(2, 144);
        wait_drain(40);

        // All four held valid after reset: grant order 0,1,2,3,0.
        do_reset();
        glog.delete();
        set_req(0, 10);
        set_req(1, 25);
        set_req(2, 200);
        set_req(3, 255);
        for (int n = 0; n < 200 && glog.size() < 5; n++) tick(1'b1);
        req_valid = '0;
        for (int i = 0; i < 5; i++) chk("grant_order", glog.size() > i ? glog[i] : -1, order[i]);
        wait_drain(100);

        // Response held 20 cycles with rsp_ready low while others request.
        rsp_ready = 1'b0;
        set_req(1, 99);
        for (int n = 0; n < 60 && !rsp_valid; n++) tick(1'b0);
        chk("rsp_arrives", 32'(rsp_valid), 1);
        set_req(3, 7);
        set_req(0, 1);
        repeat (20) tick(1'b0);
        wait_drain(100);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            gr = req_ready;
            @(posedge clk);
            #1;
            req_valid = req_valid & ~gr;
            for (int r = 0; r < NREQ; r++) begin
                if (!req_valid[r] && $urandom_range(0, 3) == 0) set_req(r, $urandom_range(0, 255));
                else if (req_valid[r] && $urandom_range(0, 15) == 0) req_valid[r] = 1'b0;
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
            eng_lat   = $urandom_range(0, 6);
        end
        req_valid = '0;
        wait_drain(100);

        // Reset three cycles into WAIT with the engine still busy.
        eng_lat = 20;
        set_req(3, 77);
        cnt = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready[3]) begin
                cnt = 1;
                break;
            end
        end
        chk("midwait_grant", cnt, 1);
        @(posedge clk);
        #1 req_valid = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_zero();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        eng_lat = 3;
        glog.delete();
        set_req(0, 50);
        set_req(2, 81);
        for (int n = 0; n < 20 && glog.size() < 1; n++) tick(1'b0);
        chk("post_reset_grant", glog.size() > 0 ? glog[0] : -1, 0);
        wait_drain(100);

        // Engine never answers.
        stall = 1'b1;
        rsp_ready = 1'b1;
        set_req(1, 30);
`ifdef SQRT_ARB_TIMEOUT_EN
        for (int n = 0; n < 200 && !rsp_valid; n++) tick(1'b0);
        chk("timeout_rsp", 32'(rsp_valid), 1);
        stall = 1'b0;
        wait_drain(20);
`else
        cnt = 0;
        repeat (100) begin
            tick(1'b0);
            cnt += int'(rsp_valid);
        end
        chk("no_rsp_without_wd", cnt, 0);
        stall = 1'b0;
        do_reset();
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
